rv32i_load_unit: RTL and testbench
==================================

RV32I_LOAD_UNIT -- requirements
Module: rv32i_load_unit

Interface
REQ-001 Parameter REG_NUM, default 16, SHALL set the register count; when 16, all rd/rs indices SHALL be masked to {1'b0, idx[3:0]}.
REQ-002 clk  input  1  sole clock; all state SHALL update on posedge clk.
REQ-003 rst_n  input  1  reset, synchronous and active-low, sampled on posedge clk.
REQ-004 req_valid  input  1  execute stage presents a load.
REQ-005 req_ready  output  1  unit accepts load this cycle.
REQ-006 req_addr  input  32  byte address of the load.
REQ-007 req_funct3  input  3  000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
REQ-008 req_rd  input  5  destination register index.
REQ-009 mem_rd_valid  output  1  read request to data memory.
REQ-010 mem_rd_ready  input  1  memory accepts the request.
REQ-011 mem_addr  output  32  word-aligned address {addr[31:2],2'b00}.
REQ-012 mem_resp_valid  input  1  read data valid.
REQ-013 mem_resp_data  input  32  read word.
REQ-014 rd_we / rd_addr / rd_data  output  1/5/32  register-file write port.
REQ-015 rs1_addr, rs2_addr  input  5  decode-stage source indices for the hazard check.
REQ-016 load_hazard  output  1  combinational; a pending load targets rs1 or rs2.
REQ-017 misaligned  output  1  one-cycle fault pulse.
REQ-018 busy  output  1  high in any state other than IDLE.

Function
REQ-019 The FSM SHALL have the states IDLE, REQ, WAIT and WB, and SHALL hold exactly one load in flight.
REQ-020 req_ready SHALL be 1 only in IDLE.
REQ-021 In IDLE with req_valid: a misaligned load (LH/LHU with addr[0]=1, LW with addr[1:0]!=0) or an undefined funct3 SHALL pulse misaligned for the next cycle, stay in IDLE, issue no memory request and perform no write.
REQ-022 In IDLE with req_valid and a legal load: addr, funct3 and the masked rd SHALL be latched, and the FSM SHALL go to REQ.
REQ-023 REQ: mem_rd_valid=1 and mem_addr stable until mem_rd_ready=1; on that cycle the FSM SHALL go to WAIT.
REQ-024 mem_resp_valid SHALL be ignored in every state except WAIT.
REQ-025 WAIT: on mem_resp_valid, the aligned data SHALL be registered into rd_data and the FSM SHALL go to WB.
REQ-026 Alignment: the byte is word>>(8*addr[1:0]) and the half is word>>(16*addr[1]).
REQ-027 LB/LH SHALL sign-extend from bit 7/15; LBU/LHU SHALL zero-extend; LW SHALL pass the word unchanged.
REQ-028 WB: rd_we SHALL be 1 for exactly one cycle with rd_addr = the latched masked rd, unless that rd is 0, in which case rd_we=0; the FSM SHALL then return to IDLE.
REQ-029 rd_we SHALL be 0 in every state except WB.
REQ-030 Zero-wait latency: accept at cycle T, mem_rd_valid at T+1, response at T+2 at the earliest, rd_we at T+3; each memory wait cycle adds one cycle.
REQ-031 load_hazard = busy && latched_rd!=0 && (masked rs1_addr==latched_rd || masked rs2_addr==latched_rd).
REQ-032 A new request SHALL NOT be accepted in the WB cycle; it SHALL be accepted the following IDLE cycle at the earliest.

Reset
REQ-033 On rst_n=0 at posedge clk: state=IDLE; all outputs (rd_we, rd_addr, rd_data, mem_rd_valid, mem_addr, misaligned, busy, load_hazard) SHALL be 0.
REQ-034 Reset mid-operation SHALL drop the in-flight load with no write.
REQ-035 A memory response arriving after reset SHALL be ignored.

Verification
REQ-036 LW addr 0x100, rd=5, mem_rd_ready=1, response 0xDEADBEEF at T+2 -> at T+3 rd_we=1, rd_addr=5, rd_data=0xDEADBEEF; mem_addr=0x100.
REQ-037 LB addr 0x103, response 0x80112233 -> rd_data=0xFFFFFF80; LBU, same stimulus -> 0x00000080; mem_addr=0x100.
REQ-038 LH addr 0x102, response 0x8001ABCD -> 0xFFFF8001; LHU, same stimulus -> 0x00008001.
REQ-039 LW addr 0x101 -> misaligned=1 for one cycle, mem_rd_valid stays 0, req_ready stays 1, no rd_we.
REQ-040 REG_NUM=16, rd=21, mem_rd_ready held 0 for 3 cycles -> mem_rd_valid held and load_hazard=1 with rs1_addr=5; write lands with rd_addr=5.
REQ-041 rst_n=0 for one cycle while in WAIT, then mem_resp_valid=1 -> no rd_we, FSM in IDLE, busy=0.

Source files
------------

// File: rtl/rv32i_load_unit_if.sv
// Load-unit bus bundle: execute-stage load request channel plus data-memory read channel.
interface rv32i_load_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [2:0]  req_funct3;
  logic [4:0]  req_rd;
  logic        mem_rd_valid;
  logic        mem_rd_ready;
  logic [31:0] mem_addr;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_data;

  modport slave (
    input  req_valid, req_addr, req_funct3, req_rd,
    output req_ready,
    output mem_rd_valid, mem_addr,
    input  mem_rd_ready, mem_resp_valid, mem_resp_data
  );

  modport master (
    output req_valid, req_addr, req_funct3, req_rd,
    input  req_ready,
    input  mem_rd_valid, mem_addr,
    output mem_rd_ready, mem_resp_valid, mem_resp_data
  );
endinterface

// File: rtl/rv32i_load_unit.sv
// RV32I load unit: one load in flight, fetches the aligned word, extracts/extends the
// addressed byte/half/word and writes it back to the register file.
module rv32i_load_unit #(
  parameter int unsigned REG_NUM = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  rv32i_load_unit_if.slave bus,
  input  logic [4:0]       i_rs1_addr,
  input  logic [4:0]       i_rs2_addr,
  output logic             o_rd_we,
  output logic [4:0]       o_rd_addr,
  output logic [31:0]      o_rd_data,
  output logic             o_load_hazard,
  output logic             o_misaligned,
  output logic             o_busy
);

  localparam int unsigned XLEN   = 32;
  localparam int unsigned RIDX_W = 5;
  localparam int unsigned F3_W   = 3;

  localparam logic [F3_W-1:0] F3_LB  = 3'b000;
  localparam logic [F3_W-1:0] F3_LH  = 3'b001;
  localparam logic [F3_W-1:0] F3_LW  = 3'b010;
  localparam logic [F3_W-1:0] F3_LBU = 3'b100;
  localparam logic [F3_W-1:0] F3_LHU = 3'b101;

  // One-hot so every state-derived output comes straight off a flop.
  typedef enum logic [3:0] {
    S_IDLE = 4'b0001,
    S_REQ  = 4'b0010,
    S_WAIT = 4'b0100,
    S_WB   = 4'b1000
  } state_e;

  state_e              r_state;
  state_e              w_state_nxt;
  logic [XLEN-1:0]     r_addr;
  logic [F3_W-1:0]     r_funct3;
  logic [RIDX_W-1:0]   r_rd;
  logic [XLEN-1:0]     r_rd_data;
  logic                r_misaligned;

  logic                w_legal;
  logic                w_accept;
  logic                w_fault;
  logic                w_capture;
  logic [7:0]          w_byte;
  logic [15:0]         w_half;
  logic [XLEN-1:0]     w_load_data;

  // With 16 registers the index MSB is forced to zero.
  function automatic logic [RIDX_W-1:0] mask_idx(input logic [RIDX_W-1:0] idx);
    if (REG_NUM == 16) mask_idx = {1'b0, idx[3:0]};
    else               mask_idx = idx;
  endfunction

  // State register and latched load context
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_addr       <= '0;
      r_funct3     <= '0;
      r_rd         <= '0;
      r_rd_data    <= '0;
      r_misaligned <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_misaligned <= w_fault;
      if (w_accept) begin
        r_addr   <= bus.req_addr;
        r_funct3 <= bus.req_funct3;
        r_rd     <= mask_idx(bus.req_rd);
      end
      if (w_capture) r_rd_data <= w_load_data;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_state_nxt = S_REQ;
      S_REQ:   if (bus.mem_rd_ready) w_state_nxt = S_WAIT;
      S_WAIT:  if (bus.mem_resp_valid) w_state_nxt = S_WB;
      S_WB:    w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Request legality and per-state control strobes
  always_comb begin
    w_legal   = 1'b0;
    w_accept  = 1'b0;
    w_fault   = 1'b0;
    w_capture = 1'b0;
    case (bus.req_funct3)
      F3_LB, F3_LBU: w_legal = 1'b1;
      F3_LH, F3_LHU: w_legal = !bus.req_addr[0];
      F3_LW:         w_legal = (bus.req_addr[1:0] == 2'b00);
      default:       w_legal = 1'b0;
    endcase
    if ((r_state == S_IDLE) && bus.req_valid) begin
      w_accept = w_legal;
      w_fault  = !w_legal;
    end
    w_capture = (r_state == S_WAIT) && bus.mem_resp_valid;
  end

  // Lane select and extension of the returned word
  always_comb begin
    w_byte      = 8'(bus.mem_resp_data >> {r_addr[1:0], 3'b000});
    w_half      = 16'(bus.mem_resp_data >> {r_addr[1], 4'b0000});
    w_load_data = bus.mem_resp_data;
    case (r_funct3)
      F3_LB:   w_load_data = {{24{w_byte[7]}}, w_byte};
      F3_LH:   w_load_data = {{16{w_half[15]}}, w_half};
      F3_LBU:  w_load_data = {24'h000000, w_byte};
      F3_LHU:  w_load_data = {16'h0000, w_half};
      default: w_load_data = bus.mem_resp_data;
    endcase
  end

  assign bus.req_ready    = (r_state == S_IDLE);
  assign bus.mem_rd_valid = (r_state == S_REQ);
  assign bus.mem_addr     = {r_addr[XLEN-1:2], 2'b00};

  assign o_busy        = (r_state != S_IDLE);
  assign o_rd_we       = (r_state == S_WB) && (r_rd != '0);
  assign o_rd_addr     = r_rd;
  assign o_rd_data     = r_rd_data;
  assign o_misaligned  = r_misaligned;
  assign o_load_hazard = o_busy && (r_rd != '0) &&
                         ((mask_idx(i_rs1_addr) == r_rd) || (mask_idx(i_rs2_addr) == r_rd));

endmodule

// File: tb/tb_rv32i_load_unit.sv
// Self-checking bench for rv32i_load_unit: directed vector table, hand-written corner
// sequences and random loads checked against an arithmetic reference model.
module tb_rv32i_load_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic        rd_we;
  logic [4:0]  rd_addr;
  logic [31:0] rd_data;
  logic        hazard;
  logic        mis;
  logic        busy;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  rv32i_load_unit_if bus();

  rv32i_load_unit #(.REG_NUM(16)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .bus           (bus),
    .i_rs1_addr    (rs1),
    .i_rs2_addr    (rs2),
    .o_rd_we       (rd_we),
    .o_rd_addr     (rd_addr),
    .o_rd_data     (rd_data),
    .o_load_hazard (hazard),
    .o_misaligned  (mis),
    .o_busy        (busy)
  );

  typedef struct {
    logic [31:0] addr;
    logic [2:0]  f3;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [31:0] word;
    int          rdly;
    int          sdly;
    logic [31:0] exp_data;
    logic [4:0]  exp_rd;
    logic        exp_we;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Reference: pick lane by byte offset with division/modulo, extend by adding the sign fill.
  function automatic void ref_load(input logic [31:0] addr, input logic [2:0] f3,
                                   input logic [31:0] word, output bit legal,
                                   output logic [31:0] data);
    longint unsigned w, b, h, k;
    w = 64'(word);
    k = 64'(addr) % 4;
    b = (w / (64'd1 << (8 * k))) % 256;
    h = (w / (64'd1 << (16 * (k / 2)))) % 65536;
    legal = 1'b1;
    data  = 32'h0;
    case (f3)
      3'd0: data = 32'(b >= 128 ? b + 64'hFFFF_FF00 : b);
      3'd1: begin legal = (k % 2 == 0); data = 32'(h >= 32768 ? h + 64'hFFFF_0000 : h); end
      3'd2: begin legal = (k == 0); data = word; end
      3'd4: data = 32'(b);
      3'd5: begin legal = (k % 2 == 0); data = 32'(h); end
      default: legal = 1'b0;
    endcase
  endfunction

  task automatic idle_inputs;
    bus.req_valid      = 1'b0;
    bus.req_addr       = 32'h0;
    bus.req_funct3     = 3'b000;
    bus.req_rd         = 5'd0;
    bus.mem_rd_ready   = 1'b0;
    bus.mem_resp_valid = 1'b0;
    bus.mem_resp_data  = 32'h0;
  endtask

  // Runs one legal load from IDLE; returns positioned in the WB cycle.
  task automatic do_load(input logic [31:0] addr, input logic [2:0] f3, input logic [4:0] rd,
                         input logic [31:0] word, input int rdly, input int sdly,
                         input logic [31:0] exp_data, input logic [4:0] exp_rd,
                         input logic exp_we, input string tag);
    logic exp_hz;
    exp_hz = (exp_rd != 5'd0) && ((rs1 % 16) == exp_rd || (rs2 % 16) == exp_rd);
    chk({tag, " req_ready idle"}, 32'(bus.req_ready), 32'd1);
    bus.req_valid  = 1'b1;
    bus.req_addr   = addr;
    bus.req_funct3 = f3;
    bus.req_rd     = rd;
    step;
    bus.req_valid  = 1'b0;
    bus.req_addr   = $urandom;
    bus.req_rd     = 5'($urandom);
    chk({tag, " mem_rd_valid"}, 32'(bus.mem_rd_valid), 32'd1);
    chk({tag, " mem_addr"}, bus.mem_addr, {addr[31:2], 2'b00});
    chk({tag, " busy"}, 32'(busy), 32'd1);
    chk({tag, " req_ready busy"}, 32'(bus.req_ready), 32'd0);
    chk({tag, " hazard"}, 32'(hazard), 32'(exp_hz));
    // Stray response while the request is still pending must be ignored.
    bus.mem_resp_valid = 1'b1;
    bus.mem_resp_data  = ~word;
    repeat (rdly) step;
    if (rdly > 0) begin
      chk({tag, " mem_rd_valid held"}, 32'(bus.mem_rd_valid), 32'd1);
      chk({tag, " mem_addr held"}, bus.mem_addr, {addr[31:2], 2'b00});
      chk({tag, " hazard held"}, 32'(hazard), 32'(exp_hz));
    end
    bus.mem_rd_ready = 1'b1;
    step;
    bus.mem_rd_ready   = 1'b0;
    bus.mem_resp_valid = 1'b0;
    chk({tag, " mem_rd_valid wait"}, 32'(bus.mem_rd_valid), 32'd0);
    chk({tag, " rd_we wait"}, 32'(rd_we), 32'd0);
    repeat (sdly) step;
    bus.mem_resp_valid = 1'b1;
    bus.mem_resp_data  = word;
    step;
    bus.mem_resp_valid = 1'b0;
    bus.mem_resp_data  = $urandom;
    chk({tag, " rd_we wb"}, 32'(rd_we), 32'(exp_we));
    if (exp_we) chk({tag, " rd_addr"}, 32'(rd_addr), 32'(exp_rd));
    chk({tag, " rd_data"}, rd_data, exp_data);
  endtask

  task automatic finish_wb(input string tag);
    step;
    chk({tag, " rd_we after wb"}, 32'(rd_we), 32'd0);
    chk({tag, " busy after wb"}, 32'(busy), 32'd0);
    chk({tag, " req_ready after wb"}, 32'(bus.req_ready), 32'd1);
  endtask

  task automatic do_bad(input logic [31:0] addr, input logic [2:0] f3, input string tag);
    chk({tag, " req_ready"}, 32'(bus.req_ready), 32'd1);
    bus.req_valid  = 1'b1;
    bus.req_addr   = addr;
    bus.req_funct3 = f3;
    bus.req_rd     = 5'd3;
    step;
    bus.req_valid  = 1'b0;
    chk({tag, " misaligned"}, 32'(mis), 32'd1);
    chk({tag, " mem_rd_valid"}, 32'(bus.mem_rd_valid), 32'd0);
    chk({tag, " req_ready stays"}, 32'(bus.req_ready), 32'd1);
    chk({tag, " busy"}, 32'(busy), 32'd0);
    chk({tag, " rd_we"}, 32'(rd_we), 32'd0);
    step;
    chk({tag, " misaligned pulse end"}, 32'(mis), 32'd0);
    chk({tag, " mem_rd_valid later"}, 32'(bus.mem_rd_valid), 32'd0);
  endtask

  vec_t vecs[12];

  initial begin
    vecs[0]  = '{32'h100, 3'b010, 5'd5,  5'd0,  32'hDEADBEEF, 0, 0, 32'hDEADBEEF, 5'd5,  1'b1};
    vecs[1]  = '{32'h103, 3'b000, 5'd1,  5'd0,  32'h80112233, 0, 0, 32'hFFFFFF80, 5'd1,  1'b1};
    vecs[2]  = '{32'h103, 3'b100, 5'd2,  5'd0,  32'h80112233, 0, 0, 32'h00000080, 5'd2,  1'b1};
    vecs[3]  = '{32'h102, 3'b001, 5'd3,  5'd0,  32'h8001ABCD, 0, 0, 32'hFFFF8001, 5'd3,  1'b1};
    vecs[4]  = '{32'h102, 3'b101, 5'd4,  5'd0,  32'h8001ABCD, 0, 0, 32'h00008001, 5'd4,  1'b1};
    vecs[5]  = '{32'h200, 3'b000, 5'd6,  5'd0,  32'h12345678, 1, 2, 32'h00000078, 5'd6,  1'b1};
    vecs[6]  = '{32'h200, 3'b001, 5'd7,  5'd0,  32'h1234F678, 0, 1, 32'hFFFFF678, 5'd7,  1'b1};
    vecs[7]  = '{32'h201, 3'b100, 5'd8,  5'd0,  32'h0000AB00, 2, 0, 32'h000000AB, 5'd8,  1'b1};
    vecs[8]  = '{32'h104, 3'b010, 5'd0,  5'd0,  32'hCAFEF00D, 0, 0, 32'hCAFEF00D, 5'd0,  1'b0};
    vecs[9]  = '{32'h108, 3'b010, 5'd21, 5'd5,  32'h13572468, 3, 0, 32'h13572468, 5'd5,  1'b1};
    vecs[10] = '{32'h102, 3'b000, 5'd16, 5'd0,  32'h00FF0000, 0, 0, 32'hFFFFFFFF, 5'd0,  1'b0};
    vecs[11] = '{32'h100, 3'b001, 5'd31, 5'd31, 32'h00007FFF, 1, 1, 32'h00007FFF, 5'd15, 1'b1};

    idle_inputs();
    rs1   = 5'd0;
    rs2   = 5'd0;
    rst_n = 1'b0;
    repeat (2) step;
    chk("reset rd_we", 32'(rd_we), 32'd0);
    chk("reset rd_addr", 32'(rd_addr), 32'd0);
    chk("reset rd_data", rd_data, 32'd0);
    chk("reset mem_rd_valid", 32'(bus.mem_rd_valid), 32'd0);
    chk("reset mem_addr", bus.mem_addr, 32'd0);
    chk("reset misaligned", 32'(mis), 32'd0);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset hazard", 32'(hazard), 32'd0);
    chk("reset req_ready", 32'(bus.req_ready), 32'd1);
    rst_n = 1'b1;
    step;

    for (int i = 0; i < 12; i++) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      rs1 = vecs[i].rs1;
      rs2 = 5'd0;
      do_load(vecs[i].addr, vecs[i].f3, vecs[i].rd, vecs[i].word, vecs[i].rdly, vecs[i].sdly,
              vecs[i].exp_data, vecs[i].exp_rd, vecs[i].exp_we, tag);
      finish_wb(tag);
    end
    rs1 = 5'd0;

    do_bad(32'h101, 3'b010, "lw_mis");
    do_bad(32'h103, 3'b001, "lh_mis");
    do_bad(32'h101, 3'b101, "lhu_mis");
    do_bad(32'h100, 3'b011, "f3_011");
    do_bad(32'h100, 3'b111, "f3_111");

    // Request presented during WB must wait for the following IDLE cycle.
    do_load(32'h300, 3'b010, 5'd9, 32'h11111111, 0, 0, 32'h11111111, 5'd9, 1'b1, "b2b_a");
    bus.req_valid  = 1'b1;
    bus.req_addr   = 32'h304;
    bus.req_funct3 = 3'b010;
    bus.req_rd     = 5'd10;
    chk("b2b req_ready in wb", 32'(bus.req_ready), 32'd0);
    step;
    chk("b2b req_ready idle", 32'(bus.req_ready), 32'd1);
    chk("b2b not accepted in wb", 32'(bus.mem_rd_valid), 32'd0);
    step;
    bus.req_valid = 1'b0;
    chk("b2b accepted", 32'(bus.mem_rd_valid), 32'd1);
    chk("b2b mem_addr", bus.mem_addr, 32'h304);
    bus.mem_rd_ready = 1'b1;
    step;
    bus.mem_rd_ready   = 1'b0;
    bus.mem_resp_valid = 1'b1;
    bus.mem_resp_data  = 32'h22222222;
    step;
    bus.mem_resp_valid = 1'b0;
    chk("b2b rd_we", 32'(rd_we), 32'd1);
    chk("b2b rd_addr", 32'(rd_addr), 32'd10);
    chk("b2b rd_data", rd_data, 32'h22222222);
    finish_wb("b2b_b");

    // Reset while waiting for the response drops the load; the late response is ignored.
    bus.req_valid  = 1'b1;
    bus.req_addr   = 32'h400;
    bus.req_funct3 = 3'b010;
    bus.req_rd     = 5'd12;
    step;
    bus.req_valid    = 1'b0;
    bus.mem_rd_ready = 1'b1;
    step;
    bus.mem_rd_ready = 1'b0;
    chk("rstwait busy before", 32'(busy), 32'd1);
    rst_n = 1'b0;
    step;
    rst_n = 1'b1;
    chk("rstwait busy", 32'(busy), 32'd0);
    chk("rstwait mem_rd_valid", 32'(bus.mem_rd_valid), 32'd0);
    chk("rstwait rd_data", rd_data, 32'd0);
    chk("rstwait rd_addr", 32'(rd_addr), 32'd0);
    bus.mem_resp_valid = 1'b1;
    bus.mem_resp_data  = 32'h55AA55AA;
    step;
    bus.mem_resp_valid = 1'b0;
    chk("rstwait rd_we", 32'(rd_we), 32'd0);
    chk("rstwait busy after resp", 32'(busy), 32'd0);
    chk("rstwait req_ready", 32'(bus.req_ready), 32'd1);
    chk("rstwait rd_data after resp", rd_data, 32'd0);
    step;
    chk("rstwait rd_we later", 32'(rd_we), 32'd0);

    for (int n = 0; n < 200; n++) begin
      logic [31:0] addr;
      logic [31:0] word;
      logic [31:0] exp;
      logic [2:0]  f3;
      logic [4:0]  rd;
      logic [4:0]  mrd;
      bit          legal;
      string       tag;
      addr = $urandom;
      word = $urandom;
      f3   = 3'($urandom_range(0, 7));
      rd   = 5'($urandom);
      rs1  = 5'($urandom);
      rs2  = 5'($urandom);
      mrd  = 5'(rd % 16);
      tag  = $sformatf("rnd%0d", n);
      ref_load(addr, f3, word, legal, exp);
      if (legal) begin
        do_load(addr, f3, rd, word, $urandom_range(0, 2), $urandom_range(0, 2),
                exp, mrd, mrd != 5'd0, tag);
        finish_wb(tag);
      end else begin
        do_bad(addr, f3, tag);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
